imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 159 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RISC-V immediate generator with a 2-entry output buffer (skid).
// Optional CSR zimm decode of opcode 1110011 enabled by defining IMMGEN_ZICSR_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      err_count
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  localparam bit RV64 = (XLEN == 64);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_fmt;
  logic             skid_illegal;
  logic [TAG_W-1:0] skid_tag;

  logic accept, pop;

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = imm_s;
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = imm_b;
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = imm_u;
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = imm_j;
      end
      7'b0110011: dec_fmt = FMT_NONE;
      7'b0011011: begin
        if (RV64) begin
          dec_fmt = FMT_I;
          dec_imm = imm_i;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      7'b0111011: dec_illegal = !RV64;
`ifdef IMMGEN_ZICSR_EN
      7'b1110011: begin
        // funct3[2] selects the immediate-operand CSR forms
        if (in_instr[14]) begin
          dec_fmt = FMT_Z;
          dec_imm = XLEN'(in_instr[19:15]);
        end else begin
          dec_fmt = FMT_I;
          dec_imm = imm_i;
        end
      end
`endif
      default: dec_illegal = 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_fmt      <= FMT_NONE;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
      err_count    <= 16'd0;
    end else begin
      if (pop) begin
        if (skid_valid) begin
          out_imm     <= skid_imm;
          out_fmt     <= skid_fmt;
          out_illegal <= skid_illegal;
          out_tag     <= skid_tag;
          skid_valid  <= 1'b0;
          in_ready    <= 1'b1;
        end else if (accept) begin
          out_imm     <= dec_imm;
          out_fmt     <= dec_fmt;
          out_illegal <= dec_illegal;
          out_tag     <= in_tag;
        end else begin
          out_valid   <= 1'b0;
        end
      end else if (!out_valid) begin
        if (accept) begin
          out_valid   <= 1'b1;
          out_imm     <= dec_imm;
          out_fmt     <= dec_fmt;
          out_illegal <= dec_illegal;
          out_tag     <= in_tag;
        end
      end else if (accept) begin
        // output register stalled: park the new result in the skid entry
        skid_valid   <= 1'b1;
        skid_imm     <= dec_imm;
        skid_fmt     <= dec_fmt;
        skid_illegal <= dec_illegal;
        skid_tag     <= in_tag;
        in_ready     <= 1'b0;
      end
      if (accept && dec_illegal && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - Randomized and directed bench for imm_gen_pipe (XLEN 32 and 64 side by side).
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic [3:0]  in_tag = 4'h0;
  logic        out_ready = 1'b0;

  logic        r32_ready, v32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [3:0]  tag32;
  logic [15:0] cnt32;

  logic        r64_ready, v64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [3:0]  tag64;
  logic [15:0] cnt64;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  tag;
  } entry_t;

  entry_t q[$];
  int err32 = 0;
  int err64 = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32),
    .err_count(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64),
    .err_count(cnt64)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference decode: immediate value as a signed integer from the ISA field layout
  function automatic void ref_decode(input logic [31:0] ins, input bit rv64,
                                     output longint imm, output int fmt, output bit ill);
    imm = 0;
    fmt = 0;
    ill = 1'b0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin fmt = 1; imm = longint'($signed(ins[31:20])); end
      7'h23: begin fmt = 2; imm = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin fmt = 3; imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
      7'h37, 7'h17: begin fmt = 4; imm = longint'($signed(ins[31:12])) * 4096; end
      7'h6F: begin fmt = 5; imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
      7'h33: fmt = 0;
      7'h1B: begin
        if (rv64) begin fmt = 1; imm = longint'($signed(ins[31:20])); end
        else ill = 1'b1;
      end
      7'h3B: ill = !rv64;
`ifdef IMMGEN_ZICSR_EN
      7'h73: begin
        if (ins[14]) begin fmt = 6; imm = longint'(ins[19:15]); end
        else begin fmt = 1; imm = longint'($signed(ins[31:20])); end
      end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [13] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h73, 7'h7F};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 12)];
    return r;
  endfunction

  task automatic compare_all();
    longint li;
    int f;
    bit il;
    chk("valid32", v32, q.size() > 0);
    chk("valid64", v64, q.size() > 0);
    chk("ready32", r32_ready, q.size() < 2);
    chk("ready64", r64_ready, q.size() < 2);
    chk("err32", cnt32, err32);
    chk("err64", cnt64, err64);
    if (q.size() > 0) begin
      ref_decode(q[0].instr, 1'b0, li, f, il);
      chk("imm32", imm32, {32'h0, li[31:0]});
      chk("fmt32", fmt32, f);
      chk("ill32", ill32, il);
      chk("tag32", tag32, q[0].tag);
      ref_decode(q[0].instr, 1'b1, li, f, il);
      chk("imm64", imm64, li);
      chk("fmt64", fmt64, f);
      chk("ill64", ill64, il);
      chk("tag64", tag64, q[0].tag);
    end
  endtask

  task automatic step(input bit iv, input logic [31:0] ins, input logic [3:0] tg, input bit ordy);
    bit acc, pp, il;
    longint li;
    int f;
    entry_t e;
    compare_all();
    in_valid  = iv;
    in_instr  = ins;
    in_tag    = tg;
    out_ready = ordy;
    acc = iv && (q.size() < 2);
    pp  = ordy && (q.size() > 0);
    if (pp) void'(q.pop_front());
    if (acc) begin
      e.instr = ins;
      e.tag   = tg;
      q.push_back(e);
      ref_decode(ins, 1'b0, li, f, il);
      if (il && err32 < 65535) err32++;
      ref_decode(ins, 1'b1, li, f, il);
      if (il && err64 < 65535) err64++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit iv);
    rst       = 1'b1;
    in_valid  = iv;
    in_instr  = 32'h0000007F;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    q.delete();
    err32 = 0;
    err64 = 0;
    chk("rst_valid32", v32, 0);
    chk("rst_valid64", v64, 0);
    chk("rst_ready32", r32_ready, 1);
    chk("rst_ready64", r64_ready, 1);
    chk("rst_imm32", imm32, 0);
    chk("rst_imm64", imm64, 0);
    chk("rst_fmt32", fmt32, 0);
    chk("rst_ill32", ill32, 0);
    chk("rst_tag32", tag32, 0);
    chk("rst_err32", cnt32, 0);
    chk("rst_err64", cnt64, 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset(1'b0);

    step(1'b1, 32'hFFF00093, 4'h1, 1'b1);
    chk("addi_imm32", imm32, 64'hFFFFFFFF);
    chk("addi_fmt32", fmt32, 1);
    chk("addi_valid32", v32, 1);

    step(1'b1, 32'hFE000EE3, 4'h2, 1'b1);
    chk("beq_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
    chk("beq_fmt64", fmt64, 3);
    step(1'b1, 32'h800000B7, 4'h3, 1'b1);
    chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    chk("lui_fmt64", fmt64, 4);
    chk("lui_imm32", imm32, 64'h80000000);

    step(1'b1, 32'h0000007F, 4'h4, 1'b1);
    chk("bad_ill32", ill32, 1);
    chk("bad_imm32", imm32, 0);
    chk("bad_fmt32", fmt32, 0);
    chk("bad_err32", cnt32, 1);

    step(1'b1, 32'h3401D073, 4'h5, 1'b1);
`ifdef IMMGEN_ZICSR_EN
    chk("csr_fmt32", fmt32, 6);
    chk("csr_imm32", imm32, 3);
`else
    chk("csr_ill32", ill32, 1);
    chk("csr_err32", cnt32, 2);
`endif
    step(1'b0, 32'h0, 4'h0, 1'b1);

    do_reset(1'b0);
    step(1'b1, 32'h00100093, 4'hA, 1'b0);
    step(1'b1, 32'h00200093, 4'hB, 1'b0);
    chk("bp_ready32", r32_ready, 0);
    step(1'b1, 32'h00300093, 4'hC, 1'b0);
    chk("bp_hold_tag", tag32, 4'hA);
    step(1'b1, 32'h00300093, 4'hC, 1'b1);
    chk("bp_tag_b", tag32, 4'hB);
    chk("bp_ready_rise", r32_ready, 1);
    step(1'b1, 32'h00300093, 4'hC, 1'b1);
    chk("bp_tag_c", tag32, 4'hC);
    step(1'b0, 32'h0, 4'h0, 1'b1);

    step(1'b1, 32'h0000007F, 4'h1, 1'b0);
    step(1'b1, 32'h0000007F, 4'h2, 1'b0);
    chk("full_ready32", r32_ready, 0);
    do_reset(1'b1);
    step(1'b0, 32'h0, 4'h0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), 4'($urandom),
           $urandom_range(0, 2) != 0);
    end

    do_reset(1'b0);
    for (int i = 0; i < 65535; i++) begin
      step(1'b1, 32'h0000007F, 4'(i), 1'b1);
    end
    chk("sat_err32", cnt32, 16'hFFFF);
    chk("sat_err64", cnt64, 16'hFFFF);
    step(1'b1, 32'h0000007F, 4'h9, 1'b1);
    chk("sat_hold32", cnt32, 16'hFFFF);
    chk("sat_hold64", cnt64, 16'hFFFF);
    step(1'b0, 32'h0, 4'h0, 1'b1);
    step(1'b0, 32'h0, 4'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
